// File: rtl/branch_resolve_queue.sv
// In-order branch record queue between fetch and execute: trains the predictor on resolve,
// detects mispredicts, redirects and flushes younger records. Optional counters: BRQ_STATS_EN.
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [31:0]      push_pc,
    input  logic             push_pred_taken,
    input  logic [31:0]      push_pred_target,
    input  logic             resolve_valid,
    input  logic             resolve_taken,
    input  logic [31:0]      resolve_target,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic             upd_taken,
    output logic             mispredict,
    output logic [31:0]      redirect_pc,
    output logic             resolve_error,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispredicts
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      pc_mem     [DEPTH];
    logic             taken_mem  [DEPTH];
    logic [31:0]      target_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;

    logic [31:0]      head_pc;
    logic             head_taken;
    logic [31:0]      head_target;
    logic             do_pop;
    logic             do_push;
    logic             flush;
    logic [31:0]      next_redirect;

    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign push_ready = !full;

    always_comb begin
        head_pc       = pc_mem[rd_ptr];
        head_taken    = taken_mem[rd_ptr];
        head_target   = target_mem[rd_ptr];
        do_pop        = resolve_valid && !empty;
        flush         = do_pop && ((head_taken != resolve_taken) ||
                                   (resolve_taken && (head_target != resolve_target)));
        // A push alongside a flush is a younger wrong-path branch and is dropped.
        do_push       = push_valid && push_ready && !flush;
        next_redirect = resolve_taken ? resolve_target : (head_pc + 32'd4);
    end

    // Entry payload is not reset; validity is carried by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr]     <= push_pc;
            taken_mem[wr_ptr]  <= push_pred_taken;
            target_mem[wr_ptr] <= push_pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count_q       <= '0;
            upd_valid     <= 1'b0;
            upd_pc        <= '0;
            upd_taken     <= 1'b0;
            mispredict    <= 1'b0;
            redirect_pc   <= '0;
            resolve_error <= 1'b0;
        end else begin
            upd_valid     <= do_pop;
            mispredict    <= flush;
            resolve_error <= resolve_valid && empty;
            if (do_pop) begin
                upd_pc    <= head_pc;
                upd_taken <= resolve_taken;
            end
            if (flush) begin
                redirect_pc <= next_redirect;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count_q     <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
            end
        end
    end

`ifdef BRQ_STATS_EN
    logic [31:0] branches_q;
    logic [31:0] mispredicts_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            branches_q    <= '0;
            mispredicts_q <= '0;
        end else begin
            if (do_pop) branches_q    <= branches_q + 32'd1;
            if (flush)  mispredicts_q <= mispredicts_q + 32'd1;
        end
    end

    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios then random traffic, every cycle
// compared against a queue-based reference model.
module tb_branch_resolve_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             push_valid = 1'b0;
    logic             push_ready;
    logic [31:0]      push_pc = '0;
    logic             push_pred_taken = 1'b0;
    logic [31:0]      push_pred_target = '0;
    logic             resolve_valid = 1'b0;
    logic             resolve_taken = 1'b0;
    logic [31:0]      resolve_target = '0;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic             upd_taken;
    logic             mispredict;
    logic [31:0]      redirect_pc;
    logic             resolve_error;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic [31:0]      stat_branches;
    logic [31:0]      stat_mispredicts;

    always #5 clk = ~clk;

    branch_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n),
        .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
        .push_pred_taken(push_pred_taken), .push_pred_target(push_pred_target),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .resolve_error(resolve_error),
        .count(count), .empty(empty), .full(full),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
    } rec_t;

    rec_t        q[$];
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] m_br   = '0;
    logic [31:0] m_mis  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input logic rn, input logic pv, input logic [31:0] ppc,
                        input logic ppt, input logic [31:0] ptg, input logic rv,
                        input logic rt, input logic [31:0] rtg);
        logic        e_uv, e_ut, e_mis, e_err;
        logic [31:0] e_upc, e_rd, e_sb, e_sm;
        bit          full_b;
        rec_t        h;
        reset_n = rn; push_valid = pv; push_pc = ppc; push_pred_taken = ppt;
        push_pred_target = ptg; resolve_valid = rv; resolve_taken = rt; resolve_target = rtg;
        e_uv = 1'b0; e_ut = 1'b0; e_mis = 1'b0; e_err = 1'b0; e_upc = '0; e_rd = '0;
        if (!rn) begin
            q.delete();
            m_br = '0;
            m_mis = '0;
        end else begin
            full_b = (q.size() == DEPTH);
            if (rv && q.size() == 0) begin
                e_err = 1'b1;
            end else if (rv) begin
                h = q.pop_front();
                e_uv = 1'b1; e_upc = h.pc; e_ut = rt;
                m_br = m_br + 32'd1;
                if (h.pt != rt || (rt && h.tgt != rtg)) begin
                    e_mis = 1'b1;
                    e_rd = rt ? rtg : h.pc + 32'd4;
                    m_mis = m_mis + 32'd1;
                    q.delete();
                end
            end
            if (pv && !full_b && !e_mis) q.push_back('{pc: ppc, pt: ppt, tgt: ptg});
        end
`ifdef BRQ_STATS_EN
        e_sb = m_br;
        e_sm = m_mis;
`else
        e_sb = '0;
        e_sm = '0;
`endif
        @(posedge clk);
        #1;
        chk("upd_valid", upd_valid, e_uv);
        if (e_uv || !rn) begin
            chk("upd_pc", upd_pc, e_upc);
            chk("upd_taken", upd_taken, e_ut);
        end
        chk("mispredict", mispredict, e_mis);
        if (e_mis || !rn) chk("redirect_pc", redirect_pc, e_rd);
        chk("resolve_error", resolve_error, e_err);
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == DEPTH);
        chk("push_ready", push_ready, q.size() != DEPTH);
        chk("stat_branches", stat_branches, e_sb);
        chk("stat_mispredicts", stat_mispredicts, e_sm);
    endtask

    task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] tg);
        step(1'b1, 1'b1, pc, pt, tg, 1'b0, 1'b0, '0);
    endtask

    task automatic resolve(input logic rt, input logic [31:0] tg);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, rt, tg);
    endtask

    initial begin
        logic        rn, pv, ppt, rv, rt;
        logic [31:0] ppc, ptg, rtg;

        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);

        push(32'h100, 1'b0, 32'h0);
        resolve(1'b0, 32'h0);
        push(32'h200, 1'b0, 32'h0);
        resolve(1'b1, 32'h240);
        push(32'h300, 1'b1, 32'h380);
        resolve(1'b0, 32'h0);
        push(32'h300, 1'b1, 32'h380);
        resolve(1'b1, 32'h390);
        push(32'hFFFF_FFFC, 1'b1, 32'h10);
        resolve(1'b0, 32'h0);
        push(32'h300, 1'b1, 32'h380);
        resolve(1'b1, 32'h380);

        for (int i = 0; i < 5; i++) push(32'h500 + 32'(i * 4), 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h700, 1'b0, '0, 1'b1, 1'b1, 32'h600);
        push(32'h800, 1'b0, 32'h0);
        resolve(1'b0, 32'h0);

        step(1'b1, 1'b1, 32'h400, 1'b0, '0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 32'h900, 1'b0, '0, 1'b1, 1'b1, 32'h123);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);

        for (int i = 0; i < 400; i++) begin
            rn  = ($urandom_range(0, 99) != 0);
            pv  = ($urandom_range(0, 2) != 0);
            ppc = $urandom & 32'hFFFF_FFFC;
            ppt = 1'($urandom_range(0, 1));
            ptg = 32'h1000 * 32'($urandom_range(1, 3));
            rv  = ($urandom_range(0, 1) != 0);
            if (q.size() != 0 && $urandom_range(0, 1) == 1) begin
                rt  = q[0].pt;
                rtg = q[0].tgt;
            end else begin
                rt  = 1'($urandom_range(0, 1));
                rtg = 32'h1000 * 32'($urandom_range(1, 3));
            end
            step(rn, pv, ppc, ppt, ptg, rv, rt, rtg);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
